// File: rtl/id_ex_reg_pkg.sv
// Shared types for the ID/EX pipeline register: FSM states, control-word layout and the bubble word.
// Widths normally come from Const.svh; the guarded defaults below keep a standalone build complete.
`ifndef CTRL_WID
`define CTRL_WID 12
`endif
`ifndef DATA_WID
`define DATA_WID 32
`endif

package id_ex_reg_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HALT   = 2'd2
    } state_t;

    localparam int CTRL_MEMREAD_BIT = 2;
    localparam logic [`CTRL_WID-1:0] CTRL_BUBBLE = '0;

    // Everything the EX stage sees, kept as one word so hold/bubble/capture are single assignments.
    typedef struct packed {
        logic                 valid;
        logic [`CTRL_WID-1:0] ctrl;
        logic [`DATA_WID-1:0] pc;
        logic [`DATA_WID-1:0] rs1_data;
        logic [`DATA_WID-1:0] rs2_data;
        logic [`DATA_WID-1:0] imm;
        logic [4:0]           rs1;
        logic [4:0]           rs2;
        logic [4:0]           rd;
        logic                 branch;
        logic                 predict;
        logic                 ujtype;
        logic                 excp;
    } ex_word_t;

    function automatic ex_word_t bubble_word();
        ex_word_t w;
        w      = '0;
        w.ctrl = CTRL_BUBBLE;
        return w;
    endfunction

endpackage

// File: rtl/id_ex_reg_hazard_detect.sv
// Load-use compare: a load in EX whose destination is read by the instruction in decode.
module hazard_detect (
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    assign load_use = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid
                    & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush, load-use bubble and ecall halt/resume.
// Load-use detection is built only when LOAD_USE_DETECT_EN is defined.
`ifndef CTRL_WID
`define CTRL_WID 12
`endif
`ifndef DATA_WID
`define DATA_WID 32
`endif

module id_ex_reg
    import id_ex_reg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [`CTRL_WID-1:0] ctrl_i,
    input  logic [`DATA_WID-1:0] pc_i,
    input  logic [`DATA_WID-1:0] rs1_data_i,
    input  logic [`DATA_WID-1:0] rs2_data_i,
    input  logic [`DATA_WID-1:0] imm_i,
    input  logic [4:0]           rs1_i,
    input  logic [4:0]           rs2_i,
    input  logic [4:0]           rd_i,
    input  logic                 branch_i,
    input  logic                 predict_i,
    input  logic                 ujtype_i,
    input  logic                 excp_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 resume_i,
    output logic                 valid_o,
    output logic [`CTRL_WID-1:0] ctrl_o,
    output logic [`DATA_WID-1:0] pc_o,
    output logic [`DATA_WID-1:0] rs1_data_o,
    output logic [`DATA_WID-1:0] rs2_data_o,
    output logic [`DATA_WID-1:0] imm_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic                 branch_o,
    output logic                 predict_o,
    output logic                 ujtype_o,
    output logic                 excp_o,
    output logic                 hold_o
);

    state_t   state_reg, state_next;
    ex_word_t ex_reg, ex_next;
    ex_word_t in_word;
    logic     load_use;

    assign in_word = '{valid: valid_i, ctrl: ctrl_i, pc: pc_i, rs1_data: rs1_data_i,
                       rs2_data: rs2_data_i, imm: imm_i, rs1: rs1_i, rs2: rs2_i, rd: rd_i,
                       branch: branch_i, predict: predict_i, ujtype: ujtype_i, excp: excp_i};

`ifdef LOAD_USE_DETECT_EN
    hazard_detect u_hazard_detect (
        .ex_valid   (ex_reg.valid),
        .ex_memread (ex_reg.ctrl[CTRL_MEMREAD_BIT]),
        .ex_rd      (ex_reg.rd),
        .id_valid   (valid_i),
        .id_rs1     (rs1_i),
        .id_rs2     (rs2_i),
        .load_use   (load_use)
    );
`else
    assign load_use = 1'b0;
`endif

    // Priority: flush > stall > halt > load-use > capture.
    always_comb begin
        ex_next    = ex_reg;
        state_next = state_reg;
        if (flush_i) begin
            ex_next = bubble_word();
            if (state_reg == BUBBLE || (state_reg == HALT && resume_i))
                state_next = RUN;
        end else if (!stall_i) begin
            if (state_reg == HALT) begin
                ex_next = bubble_word();
                if (resume_i)
                    state_next = RUN;
            end else if (load_use && state_reg == RUN) begin
                ex_next    = bubble_word();
                state_next = BUBBLE;
            end else begin
                // The held instruction after a bubble is captured here without re-checking.
                ex_next    = in_word;
                state_next = (valid_i && excp_i) ? HALT : RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= RUN;
            ex_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ex_reg    <= ex_next;
        end
    end

    assign hold_o     = stall_i | (state_reg == HALT) | load_use;
    assign valid_o    = ex_reg.valid;
    assign ctrl_o     = ex_reg.ctrl;
    assign pc_o       = ex_reg.pc;
    assign rs1_data_o = ex_reg.rs1_data;
    assign rs2_data_o = ex_reg.rs2_data;
    assign imm_o      = ex_reg.imm;
    assign rs1_o      = ex_reg.rs1;
    assign rs2_o      = ex_reg.rs2;
    assign rd_o       = ex_reg.rd;
    assign branch_o   = ex_reg.branch;
    assign predict_o  = ex_reg.predict;
    assign ujtype_o   = ex_reg.ujtype;
    assign excp_o     = ex_reg.excp;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: expected EX words are queued at drive time and checked after each edge.
// Load-use expectations follow LOAD_USE_DETECT_EN.
`ifndef CTRL_WID
`define CTRL_WID 12
`endif
`ifndef DATA_WID
`define DATA_WID 32
`endif

module tb_id_ex_reg;

    localparam int CW = `CTRL_WID;
    localparam int DW = `DATA_WID;
    localparam logic [CW-1:0] MR = CW'(1) << 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i, branch_i, predict_i, ujtype_i, excp_i;
    logic          stall_i, flush_i, resume_i;
    logic [CW-1:0] ctrl_i;
    logic [DW-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]    rs1_i, rs2_i, rd_i;
    logic          valid_o, branch_o, predict_o, ujtype_o, excp_o, hold_o;
    logic [CW-1:0] ctrl_o;
    logic [DW-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]    rs1_o, rs2_o, rd_o;

    typedef struct {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic [4:0]    rd;
        logic          excp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ctrl_i(ctrl_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .branch_i(branch_i),
        .predict_i(predict_i), .ujtype_i(ujtype_i), .excp_i(excp_i),
        .stall_i(stall_i), .flush_i(flush_i), .resume_i(resume_i),
        .valid_o(valid_o), .ctrl_o(ctrl_o), .pc_o(pc_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
        .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o), .branch_o(branch_o),
        .predict_o(predict_o), .ujtype_o(ujtype_o), .excp_o(excp_o), .hold_o(hold_o)
    );

    function automatic logic [DW-1:0] imm_of(input logic [DW-1:0] pc);
        return {pc[15:0], 16'hA5A5};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] pc,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic ex);
        valid_i = v;  ctrl_i = c;  pc_i = pc;  imm_i = imm_of(pc);
        rs1_data_i = pc ^ 32'h1111_0000;  rs2_data_i = pc ^ 32'h0000_2222;
        rs1_i = r1;  rs2_i = r2;  rd_i = rd;  excp_i = ex;
        branch_i = 1'b0;  predict_i = 1'b0;  ujtype_i = 1'b0;
    endtask

    task automatic expect_cap(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] pc,
                              input logic [4:0] rd, input logic ex);
        exp_t e;
        e.valid = v;  e.ctrl = c;  e.pc = pc;  e.imm = imm_of(pc);  e.rd = rd;  e.excp = ex;
        sb_q.push_back(e);
    endtask

    task automatic expect_bubble();
        exp_t e;
        e.valid = 1'b0;  e.ctrl = '0;  e.pc = '0;  e.imm = '0;  e.rd = '0;  e.excp = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic check_hold(input string tag, input logic exp);
        #1;
        check_val({tag, "_hold"}, 64'(hold_o), 64'(exp));
    endtask

    // Advance one edge, compare the DUT against the oldest queued expectation, return at negedge.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got valid=%0b pc=0x%0h", tag, valid_o, pc_o);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_valid"}, 64'(valid_o), 64'(e.valid));
            check_val({tag, "_ctrl"},  64'(ctrl_o),  64'(e.ctrl));
            check_val({tag, "_pc"},    64'(pc_o),    64'(e.pc));
            check_val({tag, "_imm"},   64'(imm_o),   64'(e.imm));
            check_val({tag, "_rd"},    64'(rd_o),    64'(e.rd));
            check_val({tag, "_excp"},  64'(excp_o),  64'(e.excp));
        end
        $display("%0t %s: valid=%0b ctrl=0x%0h pc=0x%0h rd=%0d excp=%0b hold=%0b",
                 $time, tag, valid_o, ctrl_o, pc_o, rd_o, excp_o, hold_o);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_valid"}, 64'(valid_o), 64'd0);
        check_val({tag, "_ctrl"},  64'(ctrl_o),  64'd0);
        check_val({tag, "_pc"},    64'(pc_o),    64'd0);
        check_val({tag, "_rd"},    64'(rd_o),    64'd0);
        check_val({tag, "_excp"},  64'(excp_o),  64'd0);
        check_val({tag, "_hold"},  64'(hold_o),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;  stall_i = 1'b0;  flush_i = 1'b0;  resume_i = 1'b0;
        drive(1'b0, '0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Normal capture
        drive(1'b1, '0, 32'h40, 5'd0, 5'd0, 5'd5, 1'b0);
        check_hold("normal", 1'b0);
        expect_cap(1'b1, '0, 32'h40, 5'd5, 1'b0);
        tick("normal");

        // lw x6 then add rs1=x6
        drive(1'b1, MR, 32'h44, 5'd1, 5'd2, 5'd6, 1'b0);
        check_hold("lw", 1'b0);
        expect_cap(1'b1, MR, 32'h44, 5'd6, 1'b0);
        tick("lw");
        drive(1'b1, '0, 32'h48, 5'd6, 5'd7, 5'd8, 1'b0);
`ifdef LOAD_USE_DETECT_EN
        check_hold("lu_rs1", 1'b1);
        expect_bubble();
        tick("lu_rs1_bubble");
        check_hold("lu_rs1_after", 1'b0);
`else
        check_hold("lu_rs1", 1'b0);
`endif
        expect_cap(1'b1, '0, 32'h48, 5'd8, 1'b0);
        tick("lu_rs1_add");

        // Load to x0 never stalls
        drive(1'b1, MR, 32'h50, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_cap(1'b1, MR, 32'h50, 5'd0, 1'b0);
        tick("lw_x0");
        drive(1'b1, MR, 32'h54, 5'd0, 5'd3, 5'd9, 1'b0);
        check_hold("rd0", 1'b0);
        expect_cap(1'b1, MR, 32'h54, 5'd9, 1'b0);
        tick("rd0_use");

        // Hazard through rs2
        drive(1'b1, '0, 32'h58, 5'd1, 5'd9, 5'd10, 1'b0);
`ifdef LOAD_USE_DETECT_EN
        check_hold("lu_rs2", 1'b1);
        expect_bubble();
        tick("lu_rs2_bubble");
`else
        check_hold("lu_rs2", 1'b0);
`endif
        expect_cap(1'b1, '0, 32'h58, 5'd10, 1'b0);
        tick("lu_rs2_use");

        // Invalid decode slot never raises a hazard
        drive(1'b1, MR, 32'h5C, 5'd0, 5'd0, 5'd11, 1'b0);
        expect_cap(1'b1, MR, 32'h5C, 5'd11, 1'b0);
        tick("lw_x11");
        drive(1'b0, '0, 32'h0, 5'd11, 5'd0, 5'd0, 1'b0);
        check_hold("nohaz_invalid", 1'b0);
        expect_cap(1'b0, '0, 32'h0, 5'd0, 1'b0);
        tick("nohaz_invalid");

        // Stall holds, then flush wins over stall
        drive(1'b1, '0, 32'h60, 5'd0, 5'd0, 5'd12, 1'b0);
        expect_cap(1'b1, '0, 32'h60, 5'd12, 1'b0);
        tick("pre_stall");
        drive(1'b1, '0, 32'h64, 5'd0, 5'd0, 5'd13, 1'b0);
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check_hold("stall", 1'b1);
            expect_cap(1'b1, '0, 32'h60, 5'd12, 1'b0);
            tick("stall");
        end
        flush_i = 1'b1;
        expect_bubble();
        tick("flush_stall");
        flush_i = 1'b0;  stall_i = 1'b0;
        check_hold("post_flush", 1'b0);
        expect_cap(1'b1, '0, 32'h64, 5'd13, 1'b0);
        tick("post_flush");

        // Ecall halt, bubbles until resume, then capture
        drive(1'b1, '0, 32'h80, 5'd0, 5'd0, 5'd0, 1'b1);
        check_hold("ecall", 1'b0);
        expect_cap(1'b1, '0, 32'h80, 5'd0, 1'b1);
        tick("ecall");
        drive(1'b1, '0, 32'h84, 5'd0, 5'd0, 5'd14, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_hold("halt", 1'b1);
            expect_bubble();
            tick("halt");
        end
        resume_i = 1'b1;
        check_hold("resume", 1'b1);
        expect_bubble();
        tick("resume");
        resume_i = 1'b0;
        check_hold("post_resume", 1'b0);
        expect_cap(1'b1, '0, 32'h84, 5'd14, 1'b0);
        tick("post_resume");

        // Resume outside halt is ignored
        resume_i = 1'b1;
        drive(1'b1, '0, 32'h88, 5'd0, 5'd0, 5'd15, 1'b0);
        expect_cap(1'b1, '0, 32'h88, 5'd15, 1'b0);
        tick("resume_run");
        resume_i = 1'b0;
        check_hold("resume_run", 1'b0);

        // Flush in halt keeps halt; flush with resume returns to run
        drive(1'b1, '0, 32'h90, 5'd0, 5'd0, 5'd0, 1'b1);
        expect_cap(1'b1, '0, 32'h90, 5'd0, 1'b1);
        tick("ecall2");
        drive(1'b1, '0, 32'h94, 5'd0, 5'd0, 5'd16, 1'b0);
        flush_i = 1'b1;
        expect_bubble();
        tick("halt_flush");
        flush_i = 1'b0;
        check_hold("halt_flush", 1'b1);
        flush_i = 1'b1;  resume_i = 1'b1;
        expect_bubble();
        tick("flush_resume");
        flush_i = 1'b0;  resume_i = 1'b0;
        check_hold("flush_resume", 1'b0);
        expect_cap(1'b1, '0, 32'h94, 5'd16, 1'b0);
        tick("flush_resume_cap");

        // Asynchronous reset while halted
        drive(1'b1, '0, 32'hA0, 5'd0, 5'd0, 5'd0, 1'b1);
        expect_cap(1'b1, '0, 32'hA0, 5'd0, 1'b1);
        tick("ecall3");
        check_hold("ecall3", 1'b1);
        #1 rst = 1'b1;
        #1 check_all_zero("async_rst");
        drive(1'b0, '0, '0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        drive(1'b1, '0, 32'hC0, 5'd0, 5'd0, 5'd17, 1'b0);
        check_hold("post_rst", 1'b0);
        expect_cap(1'b1, '0, 32'hC0, 5'd17, 1'b0);
        tick("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 valid_i  in  1  decode stage holds a valid instruction.
REQ-004 ctrl_i  in  `CTRL_WID  decoded control word {EX,MEM,WB}.
REQ-005 pc_i, rs1_data_i, rs2_data_i, imm_i  in  `DATA_WID each  decode operands.
REQ-006 rs1_i, rs2_i, rd_i  in  5 each  register indices.
REQ-007 branch_i, predict_i, ujtype_i, excp_i  in  1 each  decode flags.
REQ-008 stall_i  in  1  downstream busy; hold all EX contents.
REQ-009 flush_i  in  1  EX mispredict; kill the instruction entering EX.
REQ-010 resume_i  in  1  single-cycle pulse releasing an ecall halt.
REQ-011 Every *_i payload has a registered *_o twin of equal width; valid_o 1 marks a live EX instruction.
REQ-012 hold_o  out  1  combinational; upstream PC and IF/ID SHALL freeze while high.

Function
REQ-013 FSM states RUN, BUBBLE, HALT; priority per cycle: rst > flush_i > stall_i > HALT > load-use > normal capture.
REQ-014 Normal capture (RUN, no hazard): all *_o <= *_i next edge; latency exactly 1 cycle.
REQ-015 Bubble = valid_o 0, ctrl_o 0, branch/predict/ujtype/excp_o 0; data/index outputs don't-care but SHALL be zeroed.
REQ-016 flush_i 1: next edge loads bubble regardless of stall_i; BUBBLE -> RUN; HALT unchanged.
REQ-017 stall_i 1 (no flush): all outputs and state hold; hold_o 1.
REQ-018 Load-use: valid_o 1, ctrl_o[CTRL_MEMREAD_BIT] 1, rd_o != 0, valid_i 1, and rd_o equals rs1_i or rs2_i -> hold_o 1, bubble inserted, RUN -> BUBBLE.
REQ-019 BUBBLE lasts exactly one cycle: next edge captures held decode instruction, -> RUN; no second bubble for same pair.
REQ-020 Capturing an instruction with excp_i 1 -> HALT on that edge; excp_o 1 for one cycle only.
REQ-021 HALT: hold_o 1, bubbles loaded each cycle; resume_i 1 -> RUN next edge, instruction then captured the following edge.
REQ-022 resume_i outside HALT SHALL be ignored; resume_i and flush_i together: flush applies, state -> RUN.
REQ-023 rd 0 never triggers load-use; valid_i 0 never triggers hazard or HALT.

Reset
REQ-024 rst 1 asynchronously forces state RUN, every output register 0, hold_o 0.
REQ-025 Reset mid-stall, mid-bubble or in HALT discards the held instruction; first post-reset edge with valid_i 1 captures normally.

Configuration
REQ-026 LOAD_USE_DETECT_EN defined: REQ-018/019 active.
REQ-027 LOAD_USE_DETECT_EN undefined: no hazard logic, BUBBLE unreachable, hold_o = stall_i | (state==HALT).

Structure
REQ-028 Shared package holds: state enum (RUN/BUBBLE/HALT), CTRL_MEMREAD_BIT = 2, bubble ctrl constant; `CTRL_WID/`DATA_WID stay in Const.svh.
REQ-029 One sub-module hazard_detect (pure combinational load-use compare), instantiated only under LOAD_USE_DETECT_EN.

Verification
REQ-030 Normal: valid_i 1, pc_i 0x0000_0040, rd_i 5 -> next edge pc_o 0x40, rd_o 5, valid_o 1, hold_o 0.
REQ-031 Load-use: lw x6 in EX, decode add rs1=6 -> hold_o 1, one bubble, add in EX one cycle later; with macro off no bubble.
REQ-032 Flush+stall same cycle: flush_i 1, stall_i 1 -> next edge valid_o 0, ctrl_o 0.
REQ-033 Ecall: excp_i 1 captured -> excp_o 1 one cycle, hold_o 1 until resume_i pulse at cycle 10, capture at cycle 12.
REQ-034 Reset in HALT: rst pulse -> all outputs 0, state RUN, hold_o 0 immediately (asynchronous).
REQ-035 rd_o 0 load, rs1_i 0 -> no bubble, hold_o 0.
